// File: rtl/picorv32_ifetch_buffer.sv
// Direct-mapped instruction-word buffer between the PicoRV32 core and its AHB adapter.
// Optional IFETCH_BUFFER_STATS_EN adds saturating hit_count/miss_count outputs.
module picorv32_ifetch_buffer #(
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic        pico_clk,
  input  logic        pico_reset,
  input  logic        flush,
  input  logic        up_mem_valid,
  input  logic        up_mem_instr,
  output logic        up_mem_ready,
  input  logic [31:0] up_mem_addr,
  input  logic [31:0] up_mem_wdata,
  input  logic [3:0]  up_mem_wstrb,
  output logic [31:0] up_mem_rdata,
  output logic        dn_mem_valid,
  output logic        dn_mem_instr,
  input  logic        dn_mem_ready,
  output logic [31:0] dn_mem_addr,
  output logic [31:0] dn_mem_wdata,
  output logic [3:0]  dn_mem_wstrb,
  input  logic [31:0] dn_mem_rdata
`ifdef IFETCH_BUFFER_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned TAG_W = 30 - DEPTH_LOG2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FWD  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [TAG_W-1:0]      tag_q  [DEPTH];
  logic [TAG_W-1:0]      tag_d  [DEPTH];
  logic [31:0]           data_q [DEPTH];
  logic [31:0]           data_d [DEPTH];
  logic                  fill_q, fill_d;
  logic                  kill_q, kill_d;
  logic                  up_mem_ready_q, up_mem_ready_d;
  logic [31:0]           up_mem_rdata_q, up_mem_rdata_d;
  logic                  dn_mem_valid_q, dn_mem_valid_d;
  logic                  dn_mem_instr_q, dn_mem_instr_d;
  logic [31:0]           dn_mem_addr_q, dn_mem_addr_d;
  logic [31:0]           dn_mem_wdata_q, dn_mem_wdata_d;
  logic [3:0]            dn_mem_wstrb_q, dn_mem_wstrb_d;

  logic [DEPTH_LOG2-1:0] req_idx;
  logic [TAG_W-1:0]      req_tag;
  logic [DEPTH_LOG2-1:0] fill_idx;
  logic [TAG_W-1:0]      fill_tag;
  logic                  req_ifetch;
  logic                  req_hit;
  logic                  accept_hit;
  logic                  accept_miss;

  assign req_idx    = up_mem_addr[DEPTH_LOG2+1:2];
  assign req_tag    = up_mem_addr[31:DEPTH_LOG2+2];
  assign fill_idx   = dn_mem_addr_q[DEPTH_LOG2+1:2];
  assign fill_tag   = dn_mem_addr_q[31:DEPTH_LOG2+2];
  assign req_ifetch = up_mem_instr && (up_mem_wstrb == 4'b0000);
  assign req_hit    = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  // A same-cycle flush turns an instruction hit into a miss.
  assign accept_hit  = (state_q == S_IDLE) && up_mem_valid && req_ifetch && req_hit && !flush;
  assign accept_miss = (state_q == S_IDLE) && up_mem_valid && req_ifetch && !(req_hit && !flush);

  always_comb begin
    state_d        = state_q;
    valid_d        = valid_q;
    tag_d          = tag_q;
    data_d         = data_q;
    fill_d         = fill_q;
    kill_d         = kill_q;
    up_mem_ready_d = up_mem_ready_q;
    up_mem_rdata_d = up_mem_rdata_q;
    dn_mem_valid_d = dn_mem_valid_q;
    dn_mem_instr_d = dn_mem_instr_q;
    dn_mem_addr_d  = dn_mem_addr_q;
    dn_mem_wdata_d = dn_mem_wdata_q;
    dn_mem_wstrb_d = dn_mem_wstrb_q;

    case (state_q)
      S_IDLE: begin
        if (accept_hit) begin
          up_mem_rdata_d = data_q[req_idx];
          up_mem_ready_d = 1'b1;
          state_d        = S_RESP;
        end else if (up_mem_valid) begin
          dn_mem_valid_d = 1'b1;
          dn_mem_instr_d = up_mem_instr;
          dn_mem_addr_d  = up_mem_addr;
          dn_mem_wdata_d = up_mem_wdata;
          dn_mem_wstrb_d = up_mem_wstrb;
          fill_d         = req_ifetch;
          kill_d         = 1'b0;
          state_d        = S_FWD;
          if ((up_mem_wstrb != 4'b0000) && req_hit) begin
            valid_d[req_idx] = 1'b0;
          end
        end
      end
      S_FWD: begin
        if (flush) begin
          kill_d = 1'b1;
        end
        if (dn_mem_ready) begin
          dn_mem_valid_d = 1'b0;
          fill_d         = 1'b0;
          kill_d         = 1'b0;
          // An abandoned request still completes downstream but is not acknowledged.
          if (up_mem_valid) begin
            up_mem_ready_d = 1'b1;
            state_d        = S_RESP;
            if (dn_mem_wstrb_q == 4'b0000) begin
              up_mem_rdata_d = dn_mem_rdata;
            end
          end else begin
            state_d = S_IDLE;
          end
          if (fill_q && !kill_q && !flush) begin
            valid_d[fill_idx] = 1'b1;
            tag_d[fill_idx]   = fill_tag;
            data_d[fill_idx]  = dn_mem_rdata;
          end
        end
      end
      S_RESP: begin
        up_mem_ready_d = 1'b0;
        state_d        = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (flush) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge pico_clk) begin
    if (pico_reset) begin
      state_q        <= S_IDLE;
      valid_q        <= '0;
      fill_q         <= 1'b0;
      kill_q         <= 1'b0;
      up_mem_ready_q <= 1'b0;
      up_mem_rdata_q <= '0;
      dn_mem_valid_q <= 1'b0;
      dn_mem_instr_q <= 1'b0;
      dn_mem_addr_q  <= '0;
      dn_mem_wdata_q <= '0;
      dn_mem_wstrb_q <= '0;
    end else begin
      state_q        <= state_d;
      valid_q        <= valid_d;
      fill_q         <= fill_d;
      kill_q         <= kill_d;
      up_mem_ready_q <= up_mem_ready_d;
      up_mem_rdata_q <= up_mem_rdata_d;
      dn_mem_valid_q <= dn_mem_valid_d;
      dn_mem_instr_q <= dn_mem_instr_d;
      dn_mem_addr_q  <= dn_mem_addr_d;
      dn_mem_wdata_q <= dn_mem_wdata_d;
      dn_mem_wstrb_q <= dn_mem_wstrb_d;
    end
  end

  // Tag and data storage is qualified by valid_q, so it needs no reset.
  always_ff @(posedge pico_clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign up_mem_ready = up_mem_ready_q;
  assign up_mem_rdata = up_mem_rdata_q;
  assign dn_mem_valid = dn_mem_valid_q;
  assign dn_mem_instr = dn_mem_instr_q;
  assign dn_mem_addr  = dn_mem_addr_q;
  assign dn_mem_wdata = dn_mem_wdata_q;
  assign dn_mem_wstrb = dn_mem_wstrb_q;

`ifdef IFETCH_BUFFER_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (accept_hit && (hit_count_q != '1)) begin
      hit_count_d = hit_count_q + 32'd1;
    end
    if (accept_miss && (miss_count_q != '1)) begin
      miss_count_d = miss_count_q + 32'd1;
    end
  end

  always_ff @(posedge pico_clk) begin
    if (pico_reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`else
  logic unused_stats;
  assign unused_stats = accept_miss;
`endif

endmodule
